// File: rtl/vend_if.sv
// Keypad-to-controller interface for the vending machine.
//   master : keypad/debounce side (drives key_strobe/key_code, observes outputs)
//   slave  : vend_controller side (consumes keys, drives display/dispense/change)
// Signals:
//   key_strobe    1  one-cycle pulse, key_code valid
//   key_code      4  debounced key value
//   display_value 8  binary value for the BCD/seven-segment chain
//   dispense_a    1  product A dispense drive
//   dispense_b    1  product B dispense drive
//   change_pulse  1  one pulse per coin unit returned
//   coin_reject   1  one-cycle pulse, coin refused at the credit ceiling
//   busy          1  controller is dispensing, showing a price or paying change
interface vend_if;
    logic       key_strobe;
    logic [3:0] key_code;
    logic [7:0] display_value;
    logic       dispense_a;
    logic       dispense_b;
    logic       change_pulse;
    logic       coin_reject;
    logic       busy;

    modport master (
        output key_strobe, key_code,
        input  display_value, dispense_a, dispense_b, change_pulse, coin_reject, busy
    );

    modport slave (
        input  key_strobe, key_code,
        output display_value, dispense_a, dispense_b, change_pulse, coin_reject, busy
    );
endinterface

// File: rtl/vend_controller.sv
// Vending machine sequencing FSM.
// Accumulates coin credit from key strobes, arbitrates product selection
// against price, holds the dispense drive for a fixed time, shows the price
// after an underpaid selection and pays change back one unit per pulse.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-low reset
//   bus    slave modport of vend_if (keys in; display, dispense, change,
//          coin_reject and busy out, all registered)
module vend_controller #(
    parameter int PRICE_A     = 15,
    parameter int PRICE_B     = 25,
    parameter int MAX_CREDIT  = 99,
    parameter int DISP_CYCLES = 8,
    parameter int CHG_GAP     = 4,
    parameter int MSG_CYCLES  = 16
) (
    input  logic clk,
    input  logic reset,
    vend_if.slave bus
);
    localparam int TMAX = (DISP_CYCLES > MSG_CYCLES) ? DISP_CYCLES : MSG_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int GW   = $clog2(CHG_GAP + 1);

    localparam logic [7:0] P_A  = 8'(PRICE_A);
    localparam logic [7:0] P_B  = 8'(PRICE_B);
    localparam logic [8:0] MAX9 = 9'(MAX_CREDIT);

    localparam logic [3:0] KEY_A      = 4'hA;
    localparam logic [3:0] KEY_B      = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        IDLE,
        CREDIT,
        DISPENSE,
        SHOW_PRICE,
        CHANGE
    } state_t;

    state_t        state;
    logic [7:0]    credit;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;

    logic [7:0] display_value;
    logic       dispense_a;
    logic       dispense_b;
    logic       change_pulse;
    logic       coin_reject;
    logic       busy;

    // Coin sum is one bit wider than credit so an overflow past 255 cannot
    // wrap back under the ceiling.
    logic [8:0] coin_sum;
    logic       is_coin;
    logic       is_sel;
    logic [7:0] sel_price;

    assign coin_sum  = {1'b0, credit} + {5'b0, bus.key_code};
    assign is_coin   = (bus.key_code == 4'd1) || (bus.key_code == 4'd2) || (bus.key_code == 4'd5);
    assign is_sel    = (bus.key_code == KEY_A) || (bus.key_code == KEY_B);
    assign sel_price = (bus.key_code == KEY_A) ? P_A : P_B;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            credit        <= '0;
            timer         <= '0;
            gap_cnt       <= '0;
            display_value <= '0;
            dispense_a    <= 1'b0;
            dispense_b    <= 1'b0;
            change_pulse  <= 1'b0;
            coin_reject   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            change_pulse <= 1'b0;
            unique case (state)
                IDLE, CREDIT: begin
                    if (bus.key_strobe) begin
                        if (is_coin) begin
                            if (coin_sum <= MAX9) begin
                                credit        <= coin_sum[7:0];
                                display_value <= coin_sum[7:0];
                                state         <= CREDIT;
                            end else begin
                                coin_reject <= 1'b1;
                            end
                        end else if (is_sel) begin
                            busy <= 1'b1;
                            if (credit >= sel_price) begin
                                credit        <= credit - sel_price;
                                display_value <= credit - sel_price;
                                dispense_a    <= (bus.key_code == KEY_A);
                                dispense_b    <= (bus.key_code == KEY_B);
                                timer         <= TW'(DISP_CYCLES - 1);
                                state         <= DISPENSE;
                            end else begin
                                display_value <= sel_price;
                                timer         <= TW'(MSG_CYCLES - 1);
                                state         <= SHOW_PRICE;
                            end
                        end else if (bus.key_code == KEY_CANCEL && credit != 8'd0) begin
                            busy    <= 1'b1;
                            gap_cnt <= GW'(CHG_GAP - 1);
                            state   <= CHANGE;
                        end
                    end
                end
                DISPENSE: begin
                    if (timer == '0) begin
                        dispense_a <= 1'b0;
                        dispense_b <= 1'b0;
                        if (credit != 8'd0) begin
                            gap_cnt <= GW'(CHG_GAP - 1);
                            state   <= CHANGE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SHOW_PRICE: begin
                    if (timer == '0) begin
                        display_value <= credit;
                        busy          <= 1'b0;
                        state         <= (credit != 8'd0) ? CREDIT : IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                CHANGE: begin
                    // Credit reaching zero is seen one cycle after the last
                    // pulse, which gives the required extra busy cycle.
                    if (credit == 8'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (gap_cnt == '0) begin
                        change_pulse  <= 1'b1;
                        credit        <= credit - 1'b1;
                        display_value <= credit - 1'b1;
                        gap_cnt       <= GW'(CHG_GAP - 1);
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.display_value = display_value;
    assign bus.dispense_a    = dispense_a;
    assign bus.dispense_b    = dispense_b;
    assign bus.change_pulse  = change_pulse;
    assign bus.coin_reject   = coin_reject;
    assign bus.busy          = busy;
endmodule

// File: tb/tb_vend_controller.sv
// Testbench for vend_controller: directed scenarios plus randomized key
// traffic, checked every cycle against a schedule-based behavioural model.
module tb_vend_controller;
    localparam int PRICE_A     = 15;
    localparam int PRICE_B     = 25;
    localparam int MAX_CREDIT  = 99;
    localparam int DISP_CYCLES = 8;
    localparam int CHG_GAP     = 4;
    localparam int MSG_CYCLES  = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vend_if bus ();

    vend_controller #(
        .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .MAX_CREDIT(MAX_CREDIT),
        .DISP_CYCLES(DISP_CYCLES), .CHG_GAP(CHG_GAP), .MSG_CYCLES(MSG_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Outputs for each future cycle of a busy episode are laid out in a queue
    // when the episode starts; while the queue is non-empty keys are ignored.
    typedef struct packed {
        logic [7:0] disp;
        logic       da;
        logic       db;
        logic       cp;
        logic       cr;
        logic       busy;
    } out_t;

    out_t sched[$];
    out_t exp_o = '0;
    int   m_credit = 0;
    bit   model_on = 1'b0;

    function automatic out_t mk(int d, bit da, bit db, bit cp, bit cr, bit b);
        out_t o;
        o.disp = 8'(d); o.da = da; o.db = db; o.cp = cp; o.cr = cr; o.busy = b;
        return o;
    endfunction

    // Change payout of c units, followed by the one idle-looking cycle in
    // which keys are still ignored.
    task automatic push_change(input int c);
        for (int i = c; i > 0; i--) begin
            int waits;
            waits = (i == c) ? CHG_GAP : CHG_GAP - 1;
            for (int j = 0; j < waits; j++) sched.push_back(mk(i, 0, 0, 0, 0, 1));
            sched.push_back(mk(i - 1, 0, 0, 1, 0, 1));
        end
        sched.push_back(mk(0, 0, 0, 0, 0, 0));
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            sched.delete();
            m_credit = 0;
            exp_o = '0;
        end else if (sched.size() > 0) begin
            exp_o = sched.pop_front();
        end else begin
            exp_o = mk(m_credit, 0, 0, 0, 0, 0);
            if (bus.key_strobe) begin
                case (int'(bus.key_code))
                    1, 2, 5: begin
                        if (m_credit + int'(bus.key_code) <= MAX_CREDIT) begin
                            m_credit += int'(bus.key_code);
                            exp_o.disp = 8'(m_credit);
                        end else begin
                            exp_o.cr = 1'b1;
                        end
                    end
                    10, 11: begin
                        bit is_a;
                        int price;
                        is_a  = (bus.key_code == 4'hA);
                        price = is_a ? PRICE_A : PRICE_B;
                        if (m_credit >= price) begin
                            m_credit -= price;
                            for (int i = 0; i < DISP_CYCLES; i++)
                                sched.push_back(mk(m_credit, is_a, !is_a, 0, 0, 1));
                            if (m_credit > 0) push_change(m_credit);
                            else sched.push_back(mk(0, 0, 0, 0, 0, 0));
                            m_credit = 0;
                        end else begin
                            for (int i = 0; i < MSG_CYCLES; i++)
                                sched.push_back(mk(price, 0, 0, 0, 0, 1));
                            sched.push_back(mk(m_credit, 0, 0, 0, 0, 0));
                        end
                        exp_o = sched.pop_front();
                    end
                    12: begin
                        if (m_credit > 0) begin
                            push_change(m_credit);
                            m_credit = 0;
                            exp_o = sched.pop_front();
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            out_t act;
            act = {bus.display_value, bus.dispense_a, bus.dispense_b,
                   bus.change_pulse, bus.coin_reject, bus.busy};
            check("cycle_outputs", int'(act), int'(exp_o));
        end
    end

    // Event counters for the hand-computed expectations.
    int pulse_cnt = 0, da_cnt = 0, db_cnt = 0, rej_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (bus.change_pulse) pulse_cnt++;
        if (bus.dispense_a) da_cnt++;
        if (bus.dispense_b) db_cnt++;
        if (bus.coin_reject) rej_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] code);
        bus.key_strobe = 1'b1;
        bus.key_code   = code;
        @(negedge clk);
        bus.key_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int seen;
        bus.key_strobe = 1'b0;
        bus.key_code   = 4'h0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        model_on = 1'b1;
        check("reset_display", int'(bus.display_value), 0);
        check("reset_busy", int'(bus.busy), 0);
        reset = 1'b1;

        // Coins 5,5,5 three cycles apart
        press(4'd5); check("coin1_display", int'(bus.display_value), 5);  idle(2);
        press(4'd5); check("coin2_display", int'(bus.display_value), 10); idle(2);
        press(4'd5); check("coin3_display", int'(bus.display_value), 15);
        check("coins_no_reject", rej_cnt, 0);

        // Exact payment for A
        da_cnt = 0; pulse_cnt = 0;
        press(4'hA);
        check("dispA_started", int'(bus.dispense_a), 1);
        idle(12);
        check("dispA_len", da_cnt, DISP_CYCLES);
        check("dispA_no_change", pulse_cnt, 0);
        check("dispA_display", int'(bus.display_value), 0);

        // Overpay A by 5 -> change
        repeat (4) press(4'd5);
        da_cnt = 0; pulse_cnt = 0;
        press(4'hA);
        idle(DISP_CYCLES + 5 * CHG_GAP + 6);
        check("chg_disp_len", da_cnt, 8);
        check("chg_pulses", pulse_cnt, 5);
        check("chg_busy_end", int'(bus.busy), 0);

        // Underpaid B shows price, coin ignored meanwhile
        press(4'd5); press(4'd5);
        db_cnt = 0;
        press(4'hB);
        check("price_shown", int'(bus.display_value), 25);
        press(4'd5);
        idle(MSG_CYCLES + 1);
        check("price_back_credit", int'(bus.display_value), 10);
        check("price_no_dispense", db_cnt, 0);

        // Ceiling: 10 + 85 + 2 = 97, coin 5 rejected, coin 2 -> 99, cancel
        repeat (17) press(4'd5);
        press(4'd2);
        check("credit_97", int'(bus.display_value), 97);
        rej_cnt = 0;
        press(4'd5);
        check("reject_pulse", int'(bus.coin_reject), 1);
        check("reject_credit", int'(bus.display_value), 97);
        idle(1);
        check("reject_count", rej_cnt, 1);
        press(4'd2);
        check("credit_99", int'(bus.display_value), 99);
        pulse_cnt = 0;
        press(4'hC);
        idle(99 * CHG_GAP + 4);
        check("cancel99_pulses", pulse_cnt, 99);
        check("cancel99_display", int'(bus.display_value), 0);

        // Reset during change with 7 left
        press(4'd5); press(4'd5);
        press(4'hC);
        seen = 0;
        for (int i = 0; i < 100 && seen < 3; i++) begin
            @(negedge clk);
            if (bus.change_pulse) seen++;
        end
        check("rst_chg_reached", seen, 3);
        check("rst_chg_credit7", int'(bus.display_value), 7);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_chg_display", int'(bus.display_value), 0);
        check("rst_chg_busy", int'(bus.busy), 0);
        pulse_cnt = 0;
        idle(30);
        check("rst_chg_no_pulse", pulse_cnt, 0);
        press(4'hC);
        check("cancel0_busy", int'(bus.busy), 0);
        idle(10);
        check("cancel0_no_pulse", pulse_cnt, 0);

        // Randomized traffic, including ignored codes and occasional resets
        for (int n = 0; n < 400; n++) begin
            logic [3:0] code;
            case ($urandom_range(0, 11))
                0, 1, 2: code = 4'd5;
                3, 4:    code = 4'd2;
                5:       code = 4'd1;
                6:       code = 4'hA;
                7:       code = 4'hB;
                8:       code = 4'hC;
                default: code = 4'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 79) == 0) begin
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            press(code);
            idle($urandom_range(0, 6));
        end
        idle(MAX_CREDIT * CHG_GAP + 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
